// File: rtl/bp_be_ctx_write_sink.sv
// Context write sink for the backend.
// Queues register-push and NPC-bootstrap requests from the sys pipe in a
// small FIFO, drains them one per cycle into the register file or the
// context-storage NPC, and commits context switches only after everything
// requested before them has been written.
//
// Optional feature: define BP_BE_CTX_SINK_BYPASS_EN to let a lone request
// that arrives at an empty, idle sink drive the write outputs in the same
// cycle. Without it every write appears one cycle after it is issued.

package bp_be_ctx_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg,
        e_bp_dual_thread_cfg,
        e_bp_octa_thread_cfg
    } bp_params_e;

    localparam int reg_addr_width_gp = 5;
    localparam int dpath_width_gp    = 64;

    typedef enum logic {
        e_entry_rpush,
        e_entry_npc
    } ctx_entry_kind_e;

    function automatic int bp_thread_id_width(input bp_params_e cfg);
        case (cfg)
            e_bp_dual_thread_cfg: return 1;
            e_bp_octa_thread_cfg: return 3;
            default:              return 2;
        endcase
    endfunction

    function automatic int bp_vaddr_width(input bp_params_e cfg);
        return (cfg == e_bp_octa_thread_cfg) ? 48 : 39;
    endfunction

endpackage

module bp_be_ctx_write_sink
    import bp_be_ctx_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    parameter int         els_p       = 4,
    localparam int thread_id_width_p = bp_thread_id_width(bp_params_p),
    localparam int vaddr_width_p     = bp_vaddr_width(bp_params_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,

    input  logic                         rpush_v_i,
    input  logic [thread_id_width_p-1:0] rpush_tid_i,
    input  logic [reg_addr_width_gp-1:0] rpush_reg_i,
    input  logic [dpath_width_gp-1:0]    rpush_data_i,

    input  logic                         npc_v_i,
    input  logic [thread_id_width_p-1:0] npc_tid_i,
    input  logic [vaddr_width_p-1:0]     npc_i,

    input  logic                         ctxt_v_i,
    input  logic [thread_id_width_p-1:0] ctxt_tid_i,

    input  logic [thread_id_width_p-1:0] current_thread_id_i,
    output logic                         ready_o,
    input  logic                         pipe_wb_v_i,

    output logic                         rf_w_v_o,
    output logic [thread_id_width_p-1:0] rf_w_tid_o,
    output logic [reg_addr_width_gp-1:0] rf_w_addr_o,
    output logic [dpath_width_gp-1:0]    rf_w_data_o,

    output logic                         npc_w_v_o,
    output logic [thread_id_width_p-1:0] npc_w_tid_o,
    output logic [vaddr_width_p-1:0]     npc_w_o,

    output logic                         ctxt_switch_v_o,
    output logic [thread_id_width_p-1:0] ctxt_switch_tid_o,

    output logic                         err_o
);

    localparam int ptr_width_lp     = $clog2(els_p);
    localparam int cnt_width_lp     = $clog2(els_p + 1);
    localparam int payload_width_lp = (dpath_width_gp > vaddr_width_p) ? dpath_width_gp : vaddr_width_p;

    // One queue slot: an NPC entry carries its address in the payload field.
    typedef struct packed {
        ctx_entry_kind_e              kind;
        logic [thread_id_width_p-1:0] tid;
        logic [reg_addr_width_gp-1:0] rd;
        logic [payload_width_lp-1:0]  data;
    } entry_s;

    typedef enum logic [1:0] {
        e_idle,
        e_pend,
        e_fire
    } ctx_state_e;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    entry_s                       mem_q [els_p];
    logic [ptr_width_lp-1:0]      rptr_q, wptr_q, wptr_n, npc_idx;
    logic [cnt_width_lp-1:0]      count_q, count_n;

    entry_s                       rpush_entry, npc_entry, head, issue;
    logic                         head_v, cand_v, issue_v, direct_issue, deq_v;
    logic                         rpush_acc, npc_acc, store_rpush, store_npc;
    logic                         rf_fire, npc_fire, tid_err, drop_err, bypass_v;

    logic                         rf_w_v_q, npc_w_v_q, err_q;
    logic [thread_id_width_p-1:0] rf_w_tid_q, npc_w_tid_q;
    logic [reg_addr_width_gp-1:0] rf_w_addr_q;
    logic [dpath_width_gp-1:0]    rf_w_data_q;
    logic [vaddr_width_p-1:0]     npc_w_q;

    ctx_state_e                   state_q, state_n;
    logic [thread_id_width_p-1:0] ctx_tid_q;
    logic                         ctx_tid_load, drain_done;

    assign rpush_entry = '{kind: e_entry_rpush, tid: rpush_tid_i, rd: rpush_reg_i,
                           data: payload_width_lp'(rpush_data_i)};
    assign npc_entry   = '{kind: e_entry_npc, tid: npc_tid_i, rd: '0,
                           data: payload_width_lp'(npc_i)};

    // Two free slots are needed because a cycle may bring two requests.
    assign ready_o   = (int'(count_q) + 2) <= els_p;
    assign rpush_acc = rpush_v_i & ready_o;
    assign npc_acc   = npc_v_i & ready_o;
    assign drop_err  = (rpush_v_i | npc_v_i) & ~ready_o;

    // With an empty queue the oldest incoming request is the head, so it can
    // issue in its arrival cycle instead of taking a trip through storage.
    assign head_v       = (count_q != '0);
    assign head         = mem_q[rptr_q];
    assign issue        = head_v ? head : (rpush_v_i ? rpush_entry : npc_entry);
    assign cand_v       = head_v | rpush_v_i | npc_v_i;
    assign issue_v      = cand_v & ((issue.kind == e_entry_npc) | ~pipe_wb_v_i);
    assign direct_issue = issue_v & ~head_v;
    assign deq_v        = issue_v & head_v;

    assign store_rpush = rpush_acc & ~direct_issue;
    assign store_npc   = npc_acc & ~(direct_issue & ~rpush_v_i);

    // Register pushes to x0 or to the running thread never reach the file.
    assign rf_fire  = issue_v & (issue.kind == e_entry_rpush) & (issue.rd != '0)
                    & (issue.tid != current_thread_id_i);
    assign tid_err  = issue_v & (issue.kind == e_entry_rpush) & (issue.tid == current_thread_id_i);
    assign npc_fire = issue_v & (issue.kind == e_entry_npc);

`ifdef BP_BE_CTX_SINK_BYPASS_EN
    assign bypass_v = direct_issue & ~(rpush_v_i & npc_v_i) & ~(rf_w_v_q | npc_w_v_q);
`else
    assign bypass_v = 1'b0;
`endif

    // Write-pointer advance and slot selection for up to two stores, rpush first.
    always_comb begin
        // NOTE: blocking assignments chain here on purpose: the second increment sees the first.
        wptr_n  = wptr_q;
        npc_idx = wptr_q;
        if (store_rpush) begin
            wptr_n  = ptr_inc(wptr_n);
            npc_idx = wptr_n;
        end
        if (store_npc) begin
            wptr_n = ptr_inc(wptr_n);
        end
        count_n = count_q + cnt_width_lp'(store_rpush) + cnt_width_lp'(store_npc)
                - cnt_width_lp'(deq_v);
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= deq_v ? ptr_inc(rptr_q) : rptr_q;
            wptr_q  <= wptr_n;
            count_q <= count_n;
        end
    end

    // Queue storage; occupancy alone says which slots are meaningful.
    always_ff @(posedge clk_i) begin
        // NOTE: storage has no reset; an empty count makes stale contents unreachable.
        if (store_rpush) mem_q[wptr_q]  <= rpush_entry;
        if (store_npc)   mem_q[npc_idx] <= npc_entry;
    end

    // Registered write ports and the sticky error flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rf_w_v_q    <= 1'b0;
            rf_w_tid_q  <= '0;
            rf_w_addr_q <= '0;
            rf_w_data_q <= '0;
            npc_w_v_q   <= 1'b0;
            npc_w_tid_q <= '0;
            npc_w_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            rf_w_v_q  <= rf_fire & ~bypass_v;
            npc_w_v_q <= npc_fire & ~bypass_v;
            if (rf_fire & ~bypass_v) begin
                rf_w_tid_q  <= issue.tid;
                rf_w_addr_q <= issue.rd;
                rf_w_data_q <= issue.data[dpath_width_gp-1:0];
            end
            if (npc_fire & ~bypass_v) begin
                npc_w_tid_q <= issue.tid;
                npc_w_q     <= issue.data[vaddr_width_p-1:0];
            end
            err_q <= err_q | tid_err | drop_err;
        end
    end

`ifdef BP_BE_CTX_SINK_BYPASS_EN
    assign rf_w_v_o    = rf_w_v_q | (bypass_v & rf_fire);
    assign rf_w_tid_o  = (bypass_v & rf_fire) ? issue.tid : rf_w_tid_q;
    assign rf_w_addr_o = (bypass_v & rf_fire) ? issue.rd : rf_w_addr_q;
    assign rf_w_data_o = (bypass_v & rf_fire) ? issue.data[dpath_width_gp-1:0] : rf_w_data_q;
    assign npc_w_v_o   = npc_w_v_q | (bypass_v & npc_fire);
    assign npc_w_tid_o = (bypass_v & npc_fire) ? issue.tid : npc_w_tid_q;
    assign npc_w_o     = (bypass_v & npc_fire) ? issue.data[vaddr_width_p-1:0] : npc_w_q;
`else
    assign rf_w_v_o    = rf_w_v_q;
    assign rf_w_tid_o  = rf_w_tid_q;
    assign rf_w_addr_o = rf_w_addr_q;
    assign rf_w_data_o = rf_w_data_q;
    assign npc_w_v_o   = npc_w_v_q;
    assign npc_w_tid_o = npc_w_tid_q;
    assign npc_w_o     = npc_w_q;
`endif
    assign err_o = err_q;

    // A switch may fire only once nothing is stored, arriving, or still on the write ports.
    assign drain_done = (count_q == '0) & ~(rpush_acc | npc_acc) & ~(rf_w_v_q | npc_w_v_q);

    // Context FSM next state.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
        state_n      = state_q;
        ctx_tid_load = 1'b0;
        case (state_q)
            e_idle: begin
                if (ctxt_v_i) begin
                    state_n      = e_pend;
                    ctx_tid_load = 1'b1;
                end
            end
            e_pend: begin
                ctx_tid_load = ctxt_v_i;
                if (drain_done) state_n = e_fire;
            end
            e_fire: begin
                ctx_tid_load = ctxt_v_i;
                state_n      = ctxt_v_i ? e_pend : e_idle;
            end
            default: state_n = e_idle;
        endcase
    end

    // Context FSM state and latched target thread.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= e_idle;
            ctx_tid_q <= '0;
        end else begin
            state_q <= state_n;
            if (ctx_tid_load) ctx_tid_q <= ctxt_tid_i;
        end
    end

    assign ctxt_switch_v_o   = (state_q == e_fire);
    assign ctxt_switch_tid_o = ctx_tid_q;

endmodule

// File: doc/bp_be_ctx_write_sink.md
BP_BE_CTX_WRITE_SINK -- requirements
Module: bp_be_ctx_write_sink

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_default_cfg, which supplies thread_id_width_p (T) and vaddr_width_p (V).
REQ-002 SHALL have parameter els_p, default 4, giving the queue depth in entries; legal range is 2..16.
REQ-003 Port clk_i, input, 1 -- the single clock.
REQ-004 Port reset_n_i, input, 1 -- asynchronous, active-low reset.
REQ-005 Port rpush_v_i / rpush_tid_i / rpush_reg_i / rpush_data_i, input, 1/T/reg_addr_width_gp/dpath_width_gp -- register-push request from the sys pipe.
REQ-006 Port npc_v_i / npc_tid_i / npc_i, input, 1/T/V -- NPC bootstrap request.
REQ-007 Port ctxt_v_i / ctxt_tid_i, input, 1/T -- context-switch request.
REQ-008 Port current_thread_id_i, input, T -- the active thread.
REQ-009 Port ready_o, output, 1 -- high when at least 2 queue entries are free.
REQ-010 Port pipe_wb_v_i, input, 1 -- the pipeline owns the register-file write port this cycle.
REQ-011 Port rf_w_v_o / rf_w_tid_o / rf_w_addr_o / rf_w_data_o, output, 1/T/reg_addr_width_gp/dpath_width_gp -- register-file write.
REQ-012 Port npc_w_v_o / npc_w_tid_o / npc_w_o, output, 1/T/V -- context-storage NPC write.
REQ-013 Port ctxt_switch_v_o / ctxt_switch_tid_o, output, 1/T -- committed context switch.
REQ-014 Port err_o, output, 1 -- sticky error flag.

Function
REQ-015 SHALL hold rpush and npc requests in a single FIFO of els_p entries; each entry holds kind, tid, reg/npc, data.
REQ-016 SHALL accept up to 2 enqueues per cycle; when rpush_v_i and npc_v_i are high together, the rpush SHALL be ordered first.
REQ-017 SHALL ignore any request arriving while ready_o=0 and SHALL set err_o.
REQ-018 SHALL dequeue at most one head entry per cycle, and SHALL register all write outputs (1-cycle latency from dequeue).
REQ-019 An npc head entry SHALL dequeue unconditionally and drive npc_w_v_o=1 for exactly one cycle.
REQ-020 An rpush head entry SHALL dequeue only when pipe_wb_v_i=0 (the pipeline has priority) and then drive rf_w_v_o=1 for one cycle.
REQ-021 An rpush entry with reg=0 SHALL dequeue with no write.
REQ-022 An rpush entry with tid==current_thread_id_i SHALL dequeue with no write and SHALL set err_o.
REQ-023 Earliest drain: a request enqueued in cycle N SHALL appear on the outputs in cycle N+1.
REQ-024 Simultaneous enqueue and dequeue SHALL be allowed in the same cycle; the count SHALL update by (enqueues - dequeue), and the pointers SHALL wrap modulo els_p.
REQ-025 The context FSM SHALL have states IDLE, PEND and FIRE:
- IDLE -> PEND on ctxt_v_i, latching ctxt_tid_i.
- PEND -> FIRE when the FIFO is empty, no enqueue occurs that cycle, and no write is in flight.
- FIRE SHALL drive ctxt_switch_v_o=1 for one cycle, then return to IDLE.
REQ-026 A ctxt_v_i arriving in PEND SHALL overwrite the latched tid; a ctxt_v_i arriving in FIRE SHALL go to PEND.
REQ-027 Requests enqueued while in PEND SHALL drain before the switch fires.

Reset
REQ-028 While reset_n_i=0:
- the FIFO SHALL be empty and its pointers 0;
- the FSM SHALL be in IDLE;
- all *_v_o outputs, data outputs and err_o SHALL be 0;
- ready_o SHALL be 1.
REQ-029 Assertion of reset mid-drain or in PEND SHALL discard all queued and pending work with no further output pulses.
REQ-030 err_o SHALL clear only on reset.

Configuration
REQ-031 The macro BP_BE_CTX_SINK_BYPASS_EN SHALL control bypass.
- Defined: when the FIFO is empty and a single request can issue this cycle, it SHALL skip the FIFO and drive the outputs combinationally in cycle N; ordering rules still apply.
- Undefined: latency is as in REQ-023.

Verification
REQ-032 rpush tid=1 reg=5 data=0x1234, current=0, pipe_wb_v_i=0 -> next cycle rf_w_v_o=1, tid=1, addr=5, data=0x1234.
REQ-033 rpush tid=2 with pipe_wb_v_i=1 held 3 cycles -> rf_w_v_o stays 0 for 3 cycles, then pulses once.
REQ-034 rpush and npc (0x8000_0000) in the same cycle, both tid=3 -> rf_w pulses, then npc_w pulses the next cycle.
REQ-035 3 rpushes, then ctxt_v_i tid=2 -> ctxt_switch_v_o=1 (tid=2) only after the third rf_w pulse.
REQ-036 rpush tid==current_thread_id_i -> no rf_w pulse and err_o=1; then 3 double-enqueues with els_p=4 -> ready_o=0 and the extra requests are ignored.
